axi_mem_port_bridge: RTL and testbench



---
 rtl/axi_mem_port_bridge_if.sv | 65 ++++++
 rtl/axi_mem_port_bridge.sv | 205 ++++++++++++++++++++
 tb/tb_axi_mem_port_bridge.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_port_bridge_if.sv
// Signal bundle between an AXI4 master, the burst bridge and one host-memory port.
// The bridge uses the slave view; the master view covers the AXI master plus the memory.
interface axi_mem_port_bridge_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
);
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [MASK_WIDTH-1:0] mem_wr_datastrb;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  mem_rd_data_vld;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  mem_rd_data, mem_rd_data_vld,
        output awready, wready, bid, bresp, bvalid, arready,
        output rid, rdata, rresp, rlast, rvalid,
        output mem_wr_data, mem_wr_datastrb, mem_wr_addr, mem_rd_en, mem_rd_addr
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output mem_rd_data, mem_rd_data_vld,
        input  awready, wready, bid, bresp, bvalid, arready,
        input  rid, rdata, rresp, rlast, rvalid,
        input  mem_wr_data, mem_wr_datastrb, mem_wr_addr, mem_rd_en, mem_rd_addr
    );
endinterface

// File: rtl/axi_mem_port_bridge.sv
// AXI4 slave that splits INCR bursts into single-beat accesses on one host-memory port.
// Writes pass straight through per beat; reads go through a 2-entry return buffer.
module axi_mem_port_bridge #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int MASK_WIDTH = DATA_WIDTH / 8,
    parameter int ALIGN_BITS = $clog2(MASK_WIDTH)
) (
    input logic clk,
    input logic rst_n,
    axi_mem_port_bridge_if.slave bus
);
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_BURST = 1'b1} r_state_t;

    localparam logic [ADDR_WIDTH-1:0] BEAT_STEP = ADDR_WIDTH'(MASK_WIDTH);

    function automatic logic [ADDR_WIDTH-1:0] next_beat_addr(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}} + BEAT_STEP;
    endfunction

    w_state_t              w_state_r, w_state_s;
    logic [ID_WIDTH-1:0]   w_id_r;
    logic [ADDR_WIDTH-1:0] w_addr_r;
    logic [7:0]            w_len_r, w_cnt_r;
    logic                  awready_r, wready_r, bvalid_r, wlast_err_r;
    logic                  aw_hs_s, w_hs_s, b_hs_s, w_last_beat_s;

    r_state_t              r_state_r, r_state_s;
    logic [ID_WIDTH-1:0]   r_id_r, infl_id_r;
    logic [ADDR_WIDTH-1:0] r_addr_r;
    logic [7:0]            r_len_r, r_cnt_r;
    logic                  arready_r, inflight_r, infl_last_r;
    logic                  ar_hs_s, rd_en_s, push_s, pop_s, r_last_beat_s;
    logic [2:0]            occupancy_s;

    logic [DATA_WIDTH-1:0] fifo_data_r [2];
    logic [ID_WIDTH-1:0]   fifo_id_r   [2];
    logic                  fifo_last_r [2];
    logic                  fifo_wr_ptr_r, fifo_rd_ptr_r;
    logic [1:0]            fifo_cnt_r;

    // wlast_err_r is a sticky debug flag probed hierarchically; size/burst fields are ignored.
    logic unused_s;
    assign unused_s = ^{wlast_err_r, bus.awsize, bus.awburst, bus.arsize, bus.arburst};

    assign aw_hs_s       = bus.awvalid & awready_r;
    assign w_hs_s        = bus.wvalid & wready_r;
    assign b_hs_s        = bvalid_r & bus.bready;
    assign w_last_beat_s = (w_cnt_r == w_len_r);

    assign ar_hs_s       = bus.arvalid & arready_r;
    assign pop_s         = (fifo_cnt_r != 2'd0) & bus.rready;
    assign push_s        = bus.mem_rd_data_vld & inflight_r;
    assign r_last_beat_s = (r_cnt_r == r_len_r);

    assign bus.awready = awready_r;
    assign bus.wready  = wready_r;
    assign bus.bvalid  = bvalid_r;
    assign bus.bid     = w_id_r;
    assign bus.bresp   = 2'b00;
    assign bus.arready = arready_r;
    assign bus.rvalid  = (fifo_cnt_r != 2'd0);
    assign bus.rdata   = fifo_data_r[fifo_rd_ptr_r];
    assign bus.rid     = fifo_id_r[fifo_rd_ptr_r];
    assign bus.rlast   = fifo_last_r[fifo_rd_ptr_r];
    assign bus.rresp   = 2'b00;

    // Write FSM next-state logic
    always_comb begin
        w_state_s = w_state_r;
        case (w_state_r)
            W_IDLE:  if (aw_hs_s) w_state_s = W_DATA; else w_state_s = W_IDLE;
            W_DATA:  if (w_hs_s && w_last_beat_s) w_state_s = W_RESP; else w_state_s = W_DATA;
            W_RESP:  if (b_hs_s) w_state_s = W_IDLE; else w_state_s = W_RESP;
            default: w_state_s = W_IDLE;
        endcase
    end

    // Memory write port: live only while a W beat is accepted so nothing is written spuriously
    always_comb begin
        bus.mem_wr_data     = '0;
        bus.mem_wr_datastrb = '0;
        bus.mem_wr_addr     = '0;
        if (w_hs_s) begin
            bus.mem_wr_data     = bus.wdata;
            bus.mem_wr_datastrb = bus.wstrb;
            bus.mem_wr_addr     = w_addr_r;
        end else begin
            bus.mem_wr_datastrb = '0;
        end
    end

    // Write path state, burst context and handshake flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_r   <= W_IDLE;
            w_id_r      <= '0;
            w_addr_r    <= '0;
            w_len_r     <= 8'd0;
            w_cnt_r     <= 8'd0;
            awready_r   <= 1'b0;
            wready_r    <= 1'b0;
            bvalid_r    <= 1'b0;
            wlast_err_r <= 1'b0;
        end else begin
            w_state_r <= w_state_s;
            awready_r <= (w_state_s == W_IDLE);
            wready_r  <= (w_state_s == W_DATA);
            bvalid_r  <= (w_state_s == W_RESP);
            if (aw_hs_s) begin
                w_id_r   <= bus.awid;
                w_addr_r <= bus.awaddr;
                w_len_r  <= bus.awlen;
                w_cnt_r  <= 8'd0;
            end else if (w_hs_s) begin
                w_addr_r <= next_beat_addr(w_addr_r);
                w_cnt_r  <= w_cnt_r + 8'd1;
            end
            if (w_hs_s && (bus.wlast != w_last_beat_s)) begin
                wlast_err_r <= 1'b1;
            end
        end
    end

    // Read issue: a beat may go out only if the buffer is guaranteed a free slot when it returns
    always_comb begin
        occupancy_s = {1'b0, fifo_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        if ((r_state_r == R_BURST) && (occupancy_s < 3'd2)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
        bus.mem_rd_en   = rd_en_s;
        bus.mem_rd_addr = rd_en_s ? r_addr_r : '0;
    end

    // Read FSM next-state logic
    always_comb begin
        r_state_s = r_state_r;
        case (r_state_r)
            R_IDLE:  if (ar_hs_s) r_state_s = R_BURST; else r_state_s = R_IDLE;
            R_BURST: if (rd_en_s && r_last_beat_s) r_state_s = R_IDLE; else r_state_s = R_BURST;
            default: r_state_s = R_IDLE;
        endcase
    end

    // Read path state, burst context and in-flight beat tag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_r   <= R_IDLE;
            r_id_r      <= '0;
            r_addr_r    <= '0;
            r_len_r     <= 8'd0;
            r_cnt_r     <= 8'd0;
            arready_r   <= 1'b0;
            inflight_r  <= 1'b0;
            infl_id_r   <= '0;
            infl_last_r <= 1'b0;
        end else begin
            r_state_r  <= r_state_s;
            arready_r  <= (r_state_s == R_IDLE);
            inflight_r <= rd_en_s;
            if (rd_en_s) begin
                infl_id_r   <= r_id_r;
                infl_last_r <= r_last_beat_s;
            end
            if (ar_hs_s) begin
                r_id_r   <= bus.arid;
                r_addr_r <= bus.araddr;
                r_len_r  <= bus.arlen;
                r_cnt_r  <= 8'd0;
            end else if (rd_en_s) begin
                r_addr_r <= next_beat_addr(r_addr_r);
                r_cnt_r  <= r_cnt_r + 8'd1;
            end
        end
    end

    // Two-entry return buffer; returning data is dropped unless this bridge issued it after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_wr_ptr_r <= 1'b0;
            fifo_rd_ptr_r <= 1'b0;
            fifo_cnt_r    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_r[i] <= '0;
                fifo_id_r[i]   <= '0;
                fifo_last_r[i] <= 1'b0;
            end
        end else begin
            if (push_s) begin
                fifo_data_r[fifo_wr_ptr_r] <= bus.mem_rd_data;
                fifo_id_r[fifo_wr_ptr_r]   <= infl_id_r;
                fifo_last_r[fifo_wr_ptr_r] <= infl_last_r;
                fifo_wr_ptr_r              <= ~fifo_wr_ptr_r;
            end
            if (pop_s) begin
                fifo_rd_ptr_r <= ~fifo_rd_ptr_r;
            end
            fifo_cnt_r <= fifo_cnt_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end
endmodule

// File: tb/tb_axi_mem_port_bridge.sv
// Directed-plus-random bench for axi_mem_port_bridge: a byte-level host memory with
// 1-cycle read latency, and a reference memory that predicts every burst's outcome.
module tb_axi_mem_port_bridge;
    localparam int DW = 512;
    localparam int AW = 64;
    localparam int IW = 4;
    localparam int MW = DW / 8;

    typedef struct {
        int            cyc;
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          last;
    } rd_beat_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [MW-1:0] strb;
    } wr_beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   spurious = 0;
    int   rd_en_cnt = 0;

    logic [DW-1:0] host_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem  [logic [AW-1:0]];
    logic [DW-1:0] wd [16];
    logic [MW-1:0] ws [16];
    rd_beat_t      rd_log [$];
    wr_beat_t      wr_log [$];

    axi_mem_port_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MASK_WIDTH(MW)) bus ();

    axi_mem_port_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MASK_WIDTH(MW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Host memory port: reads see the pre-write contents of the same edge
    always @(posedge clk) begin
        logic [AW-1:0] wa;
        logic [DW-1:0] word;
        bus.mem_rd_data_vld <= bus.mem_rd_en;
        if (bus.mem_rd_en && host_mem.exists(bus.mem_rd_addr & ~64'(MW - 1)))
            bus.mem_rd_data <= host_mem[bus.mem_rd_addr & ~64'(MW - 1)];
        else
            bus.mem_rd_data <= '0;
        if (bus.mem_wr_datastrb != '0) begin
            wa   = bus.mem_wr_addr & ~64'(MW - 1);
            word = host_mem.exists(wa) ? host_mem[wa] : '0;
            for (int b = 0; b < MW; b++)
                if (bus.mem_wr_datastrb[b]) word[8*b +: 8] = bus.mem_wr_data[8*b +: 8];
            host_mem[wa] = word;
        end
    end

    // Observe accepted beats and memory strobes mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rvalid && bus.rready) rd_log.push_back('{cyc, bus.rid, bus.rdata, bus.rlast});
            if (bus.wvalid && bus.wready) wr_log.push_back('{cyc, bus.mem_wr_addr, bus.mem_wr_datastrb});
            else if (bus.mem_wr_datastrb != '0) spurious++;
            if (bus.mem_rd_en) rd_en_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [AW-1:0] align_addr(input logic [AW-1:0] a);
        return a - (a % 64'(MW));
    endfunction

    // Beat 0 keeps the raw address; later beats step whole words from the aligned base.
    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] base, input int k);
        if (k == 0) return base;
        return align_addr(base) + 64'(MW) * 64'(k);
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(align_addr(a)) ? ref_mem[align_addr(a)] : '0;
    endfunction

    task automatic ref_write(input logic [AW-1:0] base, input int len);
        logic [AW-1:0] a;
        logic [DW-1:0] word;
        for (int k = 0; k <= len; k++) begin
            a    = align_addr(beat_addr(base, k));
            word = ref_read(a);
            for (int b = 0; b < MW; b++)
                if (ws[k][b]) word[8*b +: 8] = wd[k][8*b +: 8];
            ref_mem[a] = word;
        end
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_fill(input int len, input logic full_strb);
        for (int k = 0; k <= len; k++) begin
            for (int j = 0; j < DW / 32; j++) wd[k][32*j +: 32] = $urandom;
            ws[k] = full_strb ? '1 : {$urandom, $urandom};
        end
    endtask

    task automatic axi_write(input logic [IW-1:0] id, input logic [AW-1:0] base, input int len);
        int g;
        @(posedge clk); #1;
        bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = base; bus.awlen = 8'(len);
        bus.awsize = 3'd6; bus.awburst = 2'b01;
        g = 0;
        @(negedge clk);
        while (!bus.awready && g < 50) begin @(negedge clk); g++; end
        check("aw_ready", bus.awready, 1'b1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            bus.wvalid = 1'b1; bus.wdata = wd[k]; bus.wstrb = ws[k]; bus.wlast = (k == len);
            g = 0;
            @(negedge clk);
            while (!bus.wready && g < 50) begin @(negedge clk); g++; end
            check($sformatf("w_ready%0d", k), bus.wready, 1'b1);
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        @(negedge clk);
        check("bvalid_after_last", bus.bvalid, 1'b1);
        check("bid", bus.bid, id);
        check("bresp", bus.bresp, 2'b00);
        @(negedge clk);
        check("bvalid_drop", bus.bvalid, 1'b0);
        ref_write(base, len);
    endtask

    task automatic axi_ar(input logic [IW-1:0] id, input logic [AW-1:0] base, input int len,
                          output int ar_cyc);
        int g;
        @(posedge clk); #1;
        bus.arvalid = 1'b1; bus.arid = id; bus.araddr = base; bus.arlen = 8'(len);
        bus.arsize = 3'd6; bus.arburst = 2'b01;
        g = 0;
        @(negedge clk);
        while (!bus.arready && g < 50) begin @(negedge clk); g++; end
        check("ar_ready", bus.arready, 1'b1);
        ar_cyc = cyc;
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
    endtask

    // Wait for len+1 beats and compare them against the reference memory; first_cyc<0 skips timing
    task automatic check_burst(input string tag, input logic [AW-1:0] base, input int len,
                               input logic [IW-1:0] id, input int first_cyc);
        int g = 0;
        while (rd_log.size() < len + 1 && g < 200) begin @(negedge clk); g++; end
        repeat (3) @(negedge clk);
        check({tag, "_beats"}, rd_log.size(), len + 1);
        for (int k = 0; k <= len && k < rd_log.size(); k++) begin
            check($sformatf("%s_data%0d", tag, k), rd_log[k].data, ref_read(beat_addr(base, k)));
            check($sformatf("%s_last%0d", tag, k), rd_log[k].last, (k == len));
            check($sformatf("%s_id%0d", tag, k), rd_log[k].id, id);
            if (first_cyc >= 0)
                check($sformatf("%s_cyc%0d", tag, k), rd_log[k].cyc, first_cyc + k);
        end
    endtask

    initial begin
        int            ar_cyc, en0, g;
        logic [IW-1:0] id_a, id_b;

        bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = '0; bus.awlen = 8'd0;
        bus.awsize = 3'd0; bus.awburst = 2'b00;
        bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.bready = 1'b1;
        bus.arvalid = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = 8'd0;
        bus.arsize = 3'd0; bus.arburst = 2'b00;
        bus.rready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", bus.awready, 1'b0);
        check("rst_wready", bus.wready, 1'b0);
        check("rst_bvalid", bus.bvalid, 1'b0);
        check("rst_arready", bus.arready, 1'b0);
        check("rst_rvalid", bus.rvalid, 1'b0);
        check("rst_mem_rd_en", bus.mem_rd_en, 1'b0);
        check("rst_wr_strb", bus.mem_wr_datastrb, '0);
        check("rst_rd_addr", bus.mem_rd_addr, '0);
        check("rst_rdata", bus.rdata, '0);
        check("rst_bid", bus.bid, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("awready_rise", bus.awready, 1'b1);
        check("arready_rise", bus.arready, 1'b1);

        // 4-beat write of k+1 to 0x1000
        for (int k = 0; k < 4; k++) begin wd[k] = DW'(k + 1); ws[k] = '1; end
        id_a = IW'($urandom_range(0, 15));
        wr_log.delete();
        axi_write(id_a, 64'h1000, 3);
        check("t1_wr_beats", wr_log.size(), 4);
        for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
            check($sformatf("t1_addr%0d", k), wr_log[k].addr, 64'h1000 + 64'h40 * 64'(k));
            check($sformatf("t1_cyc%0d", k), wr_log[k].cyc, wr_log[0].cyc + k);
            check($sformatf("t1_strb%0d", k), wr_log[k].strb, ws[k]);
        end

        // Read it back at full throughput
        bus.rready = 1'b1;
        rd_log.delete();
        id_b = IW'($urandom_range(0, 15));
        axi_ar(id_b, 64'h1000, 3, ar_cyc);
        check_burst("t2", 64'h1000, 3, id_b, ar_cyc + 3);
        for (int k = 0; k < 4 && k < rd_log.size(); k++)
            check($sformatf("t2_value%0d", k), rd_log[k].data, DW'(k + 1));

        // 8-beat read held off by rready: exactly two reads issued until the buffer drains
        rand_fill(7, 1'b0);
        axi_write(id_a, 64'h3000, 7);
        bus.rready = 1'b0;
        rd_log.delete();
        en0 = rd_en_cnt;
        axi_ar(id_b, 64'h3000, 7, ar_cyc);
        repeat (10) @(negedge clk);
        check("t3_issued_stalled", rd_en_cnt - en0, 2);
        check("t3_rvalid_held", bus.rvalid, 1'b1);
        @(posedge clk); #1;
        bus.rready = 1'b1;
        check_burst("t3", 64'h3000, 7, id_b, -1);
        check("t3_issued_total", rd_en_cnt - en0, 8);

        // Unaligned partial-strobe write, then single-beat read of the word
        rand_fill(1, 1'b1);
        axi_write(id_a, 64'h2000, 1);
        rand_fill(1, 1'b1);
        ws[0] = MW'(64'h0F); ws[1] = MW'(64'h0F);
        wr_log.delete();
        axi_write(id_a, 64'h2004, 1);
        check("t4_wr_beats", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            check("t4_addr0", wr_log[0].addr, 64'h2004);
            check("t4_addr1", wr_log[1].addr, 64'h2040);
        end
        rd_log.delete();
        axi_ar(id_b, 64'h2000, 0, ar_cyc);
        check_burst("t4", 64'h2000, 0, id_b, ar_cyc + 3);

        // Concurrent write and read bursts on different addresses
        rand_fill(1, 1'b0);
        rd_log.delete();
        id_b = IW'($urandom_range(0, 15));
        fork
            axi_write(id_a, 64'h5000, 1);
            axi_ar(id_b, 64'h1000, 1, ar_cyc);
        join
        check_burst("t5r", 64'h1000, 1, id_b, ar_cyc + 3);
        rd_log.delete();
        axi_ar(id_b, 64'h5000, 1, ar_cyc);
        check_burst("t5w", 64'h5000, 1, id_b, ar_cyc + 3);

        // Reset in the middle of a read burst with a beat buffered
        bus.rready = 1'b0;
        rd_log.delete();
        axi_ar(id_a, 64'h3000, 3, ar_cyc);
        g = 0;
        @(negedge clk);
        while (!bus.rvalid && g < 20) begin @(negedge clk); g++; end
        check("t6_buffered", bus.rvalid, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_rvalid_cleared", bus.rvalid, 1'b0);
        check("t6_rd_en_cleared", bus.mem_rd_en, 1'b0);
        check("t6_arready_cleared", bus.arready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.rready = 1'b1;
        rd_log.delete();
        id_b = IW'($urandom_range(0, 15));
        axi_ar(id_b, 64'h3000, 3, ar_cyc);
        check_burst("t6", 64'h3000, 3, id_b, ar_cyc + 3);

        check("no_spurious_writes", spurious, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
